// File: rtl/rv_ctrl_pkg.sv
// Shared types for the multicycle RV32I controller: FSM states, opcodes, datapath select encodings.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rv_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_LUI,
        S_AUIPC,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_LINK,
        S_JUMP_PC,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_PASS_B = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALUOUT  = 2'b00,
        RES_MEMDATA = 2'b01,
        RES_ALU     = 2'b10
    } result_t;

    // First execute state for an opcode; unknown opcodes land in S_ILLEGAL.
    function automatic state_t decode_dispatch(input logic [6:0] op);
        state_t s;
        case (op)
            OP_R:               s = S_EXEC_R;
            OP_IMM:             s = S_EXEC_I;
            OP_LOAD, OP_STORE:  s = S_MEM_ADDR;
            OP_BRANCH:          s = S_BRANCH;
            OP_JAL:             s = S_JAL;
            OP_JALR:            s = S_JALR;
            OP_LUI:             s = S_LUI;
            OP_AUIPC:           s = S_AUIPC;
            default:            s = S_ILLEGAL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch resolution: funct3 plus ALU compare flags -> taken.
// Latency: purely combinational.
// Backpressure: none.
module branch_cond
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = alu_zero;
            F3_BNE:  taken = !alu_zero;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = !alu_lt;
            F3_BLTU: taken = alu_ltu;
            F3_BGEU: taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the multicycle RV32I datapath; ILLEGAL_TRAP_EN makes illegal opcodes a sticky trap.
// Latency (zero-wait memory): R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL 4, JALR 5 cycles.
// Backpressure: mem_req/addr_sel/mem_we held in FETCH/MEM_RD/MEM_WR until mem_ready; ready elsewhere ignored.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_ADDR_SEL = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] src_a_sel,
    output logic [1:0] src_b_sel,
    output logic [1:0] result_sel,
    output logic [1:0] alu_op,
    output logic       illegal
);

    state_t  state_q;
    state_t  state_d;
    logic    br_taken;
    src_a_t  src_a;
    src_b_t  src_b;
    result_t result;
    alu_op_t alu;

    branch_cond u_branch_cond (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .alu_ltu  (alu_ltu),
        .taken    (br_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = decode_dispatch(opcode);
            S_EXEC_R,
            S_EXEC_I,
            S_LUI,
            S_AUIPC:     state_d = S_ALU_WB;
            S_ALU_WB,
            S_MEM_WB,
            S_BRANCH,
            S_JUMP_PC:   state_d = S_FETCH;
            S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
            S_JAL,
            S_JALR_LINK: state_d = S_JUMP_PC;
            S_JALR:      state_d = S_JALR_LINK;
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL:   state_d = S_ILLEGAL;
`else
            S_ILLEGAL:   state_d = S_FETCH;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        illegal  = 1'b0;
        src_a    = SRCA_PC;
        src_b    = SRCB_RS2;
        result   = RES_ALUOUT;
        alu      = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                src_b   = SRCB_FOUR;
                result  = RES_ALU;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_DECODE: begin
                // Branch target (oldPC + imm) is parked in ALUOut here.
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
            end
            S_EXEC_R: begin
                src_a = SRCA_RS1;
                src_b = SRCB_RS2;
                alu   = ALU_FUNCT;
            end
            S_EXEC_I: begin
                src_a = SRCA_RS1;
                src_b = SRCB_IMM;
                alu   = ALU_FUNCT;
            end
            S_LUI: begin
                src_b = SRCB_IMM;
                alu   = ALU_PASS_B;
            end
            S_AUIPC: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
            end
            S_ALU_WB: begin
                result = RES_ALUOUT;
                reg_we = 1'b1;
            end
            S_MEM_ADDR, S_JALR: begin
                src_a = SRCA_RS1;
                src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                result = RES_MEMDATA;
                reg_we = 1'b1;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
            end
            S_BRANCH: begin
                src_a  = SRCA_RS1;
                src_b  = SRCB_RS2;
                alu    = ALU_SUB;
                result = RES_ALUOUT;
                pc_we  = br_taken;
            end
            S_JAL, S_JALR_LINK: begin
                // Link value oldPC + 4 goes straight from the ALU to rd.
                src_a  = SRCA_OLDPC;
                src_b  = SRCB_FOUR;
                result = RES_ALU;
                reg_we = 1'b1;
            end
            S_JUMP_PC: begin
                result = RES_ALUOUT;
                pc_we  = 1'b1;
            end
            S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                illegal = 1'b1;
`else
                illegal = 1'b0;
`endif
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase

        // Reset masks everything, so a coincident mem_ready cannot fire an enable.
        if (rst) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            reg_we   = 1'b0;
            illegal  = 1'b0;
            src_a    = SRCA_PC;
            src_b    = SRCB_RS2;
            result   = result_t'(RESET_ADDR_SEL);
            alu      = ALU_ADD;
        end
    end

    assign src_a_sel  = src_a;
    assign src_b_sel  = src_b;
    assign result_sel = result;
    assign alu_op     = alu;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output sequences, random waits and operands.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero, alu_lt, alu_ltu, mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, illegal;
    logic [1:0] src_a_sel, src_b_sel, result_sel, alu_op;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .alu_ltu    (alu_ltu),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .src_a_sel  (src_a_sel),
        .src_b_sel  (src_b_sel),
        .result_sel (result_sel),
        .alu_op     (alu_op),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic       mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we;
        logic [1:0] src_a, src_b, res, alu;
        logic       ill;
    } outv_t;

    typedef struct packed {
        logic  rdy;
        outv_t o;
    } cyc_t;

    cyc_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    outv_t obs;
    cyc_t  c;

    function automatic outv_t ov(input logic req, we, addr, irwe, pcwe, regwe,
                                 input logic [1:0] a, b, res, alu, input logic ill);
        outv_t v;
        v.mem_req = req;  v.mem_we = we;  v.addr_sel = addr;
        v.ir_we = irwe;   v.pc_we = pcwe; v.reg_we = regwe;
        v.src_a = a;      v.src_b = b;    v.res = res; v.alu = alu; v.ill = ill;
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(input logic rdy, input outv_t o);
        cyc_t x;
        x.rdy = rdy;
        x.o   = o;
        exp_q.push_back(x);
    endfunction

    // Architectural branch outcome from the two register operands.
    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Expected per-cycle control outputs for one instruction, with fw fetch waits and mw memory waits.
    function automatic void model_instr(input logic [6:0] op, input logic taken, input int fw, input int mw);
        outv_t wb   = ov(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 0);
        outv_t jump = ov(0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0, 0);
        outv_t link = ov(0,0,0,0,0,1, 2'd1,2'd2,2'd2,2'd0, 0);
        outv_t agen = ov(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 0);
        for (int i = 0; i < fw; i++) add(1'b0, ov(1,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0));
        add(1'b1, ov(1,0,0,1,1,0, 2'd0,2'd2,2'd2,2'd0, 0));
        add(rb(), ov(0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 0));
        case (op)
            OP_R:     begin add(rb(), ov(0,0,0,0,0,0, 2'd2,2'd0,2'd0,2'd2, 0)); add(rb(), wb); end
            OP_IMM:   begin add(rb(), ov(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd2, 0)); add(rb(), wb); end
            OP_LUI:   begin add(rb(), ov(0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd3, 0)); add(rb(), wb); end
            OP_AUIPC: begin add(rb(), ov(0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 0)); add(rb(), wb); end
            OP_LOAD: begin
                add(rb(), agen);
                for (int i = 0; i < mw; i++) add(1'b0, ov(1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0));
                add(1'b1, ov(1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0));
                add(rb(), ov(0,0,0,0,0,1, 2'd0,2'd0,2'd1,2'd0, 0));
            end
            OP_STORE: begin
                add(rb(), agen);
                for (int i = 0; i < mw; i++) add(1'b0, ov(1,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0));
                add(1'b1, ov(1,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0));
            end
            OP_BRANCH: add(rb(), ov(0,0,0,0,taken,0, 2'd2,2'd0,2'd0,2'd1, 0));
            OP_JAL:    begin add(rb(), link); add(rb(), jump); end
            OP_JALR:   begin add(rb(), agen); add(rb(), link); add(rb(), jump); end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) add(rb(), ov(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1));
`else
                add(rb(), ov(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0));
`endif
            end
        endcase
    endfunction

    task automatic step(input logic rdy, input logic r, output outv_t o);
        @(negedge clk);
        mem_ready = rdy;
        rst       = r;
        #1;
        o = ov(mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we,
               src_a_sel, src_b_sel, result_sel, alu_op, illegal);
    endtask

    // Present a new instruction and operand-derived compare flags; returns the architectural branch outcome.
    task automatic load_instr(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] a, b, output logic taken);
        opcode   = op;
        funct3   = f3;
        alu_zero = (a - b) == 32'd0;
        alu_lt   = $signed(a) < $signed(b);
        alu_ltu  = a < b;
        taken    = ref_taken(f3, a, b);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, obs);
            checks++;
            if (obs !== ov(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0)) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h want %h", i, obs, ov(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0));
            end
        end
        step(1'b0, 1'b0, obs);
        checks++;
        if (obs !== ov(1,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0)) begin
            errors++;
            $display("FAIL reset_release_fetch: got %h want %h", obs, ov(1,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0));
        end
    endtask

    task automatic test_directed();
        logic [6:0] ops [7] = '{OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_STORE, OP_JAL, OP_JALR};
        logic t;
        for (int k = 0; k < 7; k++) begin
            load_instr(ops[k], 3'd0, 32'd1, 32'd2, t);
            model_instr(ops[k], t, 0, 0);
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                step(c.rdy, 1'b0, obs);
                checks++;
                if (obs !== c.o) begin
                    errors++;
                    $display("FAIL directed op %b: got %h want %h", ops[k], obs, c.o);
                end
            end
        end
    endtask

    task automatic test_load_wait();
        logic t;
        load_instr(OP_LOAD, 3'd2, 32'd0, 32'd0, t);
        model_instr(OP_LOAD, t, 1, 3);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            step(c.rdy, 1'b0, obs);
            checks++;
            if (obs !== c.o) begin
                errors++;
                $display("FAIL load_wait: got %h want %h", obs, c.o);
            end
        end
    endtask

    task automatic test_branch();
        logic t;
        logic [31:0] a, b;
        for (int k = 0; k < 16; k++) begin
            a = (k < 2) ? 32'd7 : $urandom;
            b = (k == 0) ? 32'd7 : (k == 1) ? 32'd9 : ($urandom_range(0, 3) == 0 ? a : $urandom);
            load_instr(OP_BRANCH, (k < 2) ? 3'd0 : 3'($urandom_range(0, 7)), a, b, t);
            model_instr(OP_BRANCH, t, 0, 0);
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                step(c.rdy, 1'b0, obs);
                checks++;
                if (obs !== c.o) begin
                    errors++;
                    $display("FAIL branch f3 %0d a %h b %h: got %h want %h", funct3, a, b, obs, c.o);
                end
            end
        end
    endtask

    task automatic test_random_mix();
        logic [6:0] ops [10] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                 OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'h7F};
        logic [6:0] op;
        logic [31:0] a, b;
        logic t;
        for (int n = 0; n < 200; n++) begin
`ifdef ILLEGAL_TRAP_EN
            op = ops[$urandom_range(0, 8)];
`else
            op = ops[$urandom_range(0, 9)];
            if (op == 7'h7F) begin
                op = 7'($urandom_range(0, 127));
                while (op == OP_R || op == OP_IMM || op == OP_LOAD || op == OP_STORE ||
                       op == OP_BRANCH || op == OP_JAL || op == OP_JALR || op == OP_LUI ||
                       op == OP_AUIPC)
                    op = 7'($urandom_range(0, 127));
            end
`endif
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            load_instr(op, 3'($urandom_range(0, 7)), a, b, t);
            model_instr(op, t, $urandom_range(0, 2), $urandom_range(0, 3));
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                step(c.rdy, 1'b0, obs);
                checks++;
                if (obs !== c.o) begin
                    errors++;
                    $display("FAIL random instr %0d op %b: got %h want %h", n, op, obs, c.o);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic t;
        load_instr(7'h7F, 3'd0, 32'd0, 32'd1, t);
        model_instr(7'h7F, t, 0, 0);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            step(c.rdy, 1'b0, obs);
            checks++;
            if (obs !== c.o) begin
                errors++;
                $display("FAIL illegal: got %h want %h", obs, c.o);
            end
        end
        step(1'b1, 1'b1, obs);
        checks++;
        if (obs !== ov(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0)) begin
            errors++;
            $display("FAIL illegal_reset: got %h want 0", obs);
        end
        step(1'b0, 1'b0, obs);
        checks++;
        if (obs !== ov(1,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0)) begin
            errors++;
            $display("FAIL illegal_after_reset_fetch: got %h want %h", obs, ov(1,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0));
        end
    endtask

    task automatic test_reset_mid_store();
        logic t;
        load_instr(OP_STORE, 3'd2, 32'd0, 32'd0, t);
        model_instr(OP_STORE, t, 0, 2);
        void'(exp_q.pop_back());
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            step(c.rdy, 1'b0, obs);
            checks++;
            if (obs !== c.o) begin
                errors++;
                $display("FAIL mid_store_setup: got %h want %h", obs, c.o);
            end
        end
        step(1'b1, 1'b1, obs);
        checks++;
        if (obs !== ov(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0)) begin
            errors++;
            $display("FAIL mid_store_reset_with_ready: got %h want 0", obs);
        end
        step(1'b0, 1'b0, obs);
        checks++;
        if (obs !== ov(1,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0)) begin
            errors++;
            $display("FAIL mid_store_back_to_fetch: got %h want %h", obs, ov(1,0,0,0,0,0, 2'd0,2'd2,2'd2,2'd0, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'd0;
        funct3 = 3'd0;
        alu_zero = 1'b0;
        alu_lt = 1'b0;
        alu_ltu = 1'b0;
        test_reset();
        test_directed();
        test_load_wait();
        test_branch();
        test_random_mix();
        test_reset_mid_store();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
